// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic datapath blocks.
//   DEF_WIDTH / DEF_DIGIT : default operand width and bits handled per clock
//   NDIGITS / CNT_W       : digit count and digit-counter width for the defaults
//   state_e               : sequencer state encoding (IDLE=0, RUN=1, DONE=2)
package arith_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DIGIT = 4;
    localparam int NDIGITS   = DEF_WIDTH / DEF_DIGIT;
    localparam int CNT_W     = $clog2(NDIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-bit borrow-ripple subtract slice: {bout, d} = x - y - bin.
//   x, y : digit of the minuend / subtrahend
//   bin  : borrow into the least significant bit of the digit
//   d    : digit difference
//   bout : borrow out of the most significant bit of the digit
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    always_comb begin
        logic br;
        br = bin;
        d  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            // Borrow when x < y at this bit, or they are equal and a borrow is pending.
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_subtractor_64.sv
// Multi-cycle subtractor: diff = a - b - b_in (mod 2^WIDTH), DIGIT bits per clock.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : request, sampled only in IDLE or DONE
//   a, b, b_in      : operands, captured when start is accepted
//   busy            : a subtraction is in progress
//   done            : one-cycle pulse; diff/b_out/ovf are final from this cycle on
//   diff            : result, held until the next accepted start
//   b_out           : final borrow (unsigned a < b + b_in)
//   ovf             : two's-complement overflow of the subtraction
//   dbg_state       : current sequencer state (arith_pkg::state_e encoding)
//
// Handshake: start is accepted on any rising edge where start=1 and the block is
// in IDLE or DONE (busy=0); it is not queued, and start/operands are ignored while
// busy=1. Each accepted start yields exactly one done pulse WIDTH/DIGIT+1 edges
// later unless reset intervenes; busy and done are never high together.
module serial_subtractor_64
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N_DIG    = WIDTH / DIGIT;
    localparam int CNT_BITS = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int DIG_LG   = $clog2(DIGIT);
    localparam int POS_W    = CNT_BITS + DIG_LG;
    localparam logic [CNT_BITS-1:0] LAST_DIG = CNT_BITS'(N_DIG - 1);

    state_e              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                borrow_q;
    logic [WIDTH-1:0]    diff_q;
    logic                b_out_q;
    logic                ovf_q;
    logic                busy_q;
    logic                done_q;

    logic [POS_W-1:0]    bit_pos;
    logic [DIGIT-1:0]    digit_d;
    logic                borrow_d;

    // LSB position of the digit selected by the counter (DIGIT is a power of two).
    assign bit_pos = {cnt_q, {DIG_LG{1'b0}}};

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .x   (a_q[bit_pos +: DIGIT]),
        .y   (b_q[bit_pos +: DIGIT]),
        .bin (borrow_q),
        .d   (digit_d),
        .bout(borrow_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= b_in;
                        cnt_q    <= '0;
                        diff_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    diff_q[bit_pos +: DIGIT] <= digit_d;
                    borrow_q                 <= borrow_d;
                    if (cnt_q == LAST_DIG) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        b_out_q <= borrow_d;
                        // The top digit being written carries the result sign bit.
                        ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (digit_d[DIGIT-1] != a_q[WIDTH-1]);
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_64.sv
module tb_serial_subtractor_64;

    localparam int W     = 64;
    localparam int EXP_W = 3 * W + 3;  // {a, b, b_in, diff, b_out, ovf}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         busy, done, b_out, ovf;
    logic [W-1:0] diff;
    logic [1:0]   dbg_state;

    serial_subtractor_64 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .b_out    (b_out),
        .ovf      (ovf),
        .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EXP_W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                               input logic mbin);
        logic [W:0] full;
        logic       movf;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        movf = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
        return {ma, mb, mbin, full[W-1:0], full[W], movf};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [W-1:0]     hold_diff = '0;
    logic             hold_bout = 1'b0;
    logic             hold_ovf  = 1'b0;
    logic             hold_valid = 1'b0;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        check("busy_done_exclusive", {63'd0, busy & done}, '0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, '0);
            end else begin
                e = exp_q.pop_front();
                check("sb_diff",  diff,  e[W+1:2]);
                check("sb_b_out", {63'd0, b_out}, {63'd0, e[1]});
                check("sb_ovf",   {63'd0, ovf},   {63'd0, e[0]});
                // a == diff + b + b_in (mod 2^W), using the operands held in the entry
                check("sb_identity", diff + e[2*W+2:W+3] + {63'd0, e[W+2]}, e[EXP_W-1:2*W+3]);
                hold_diff  = e[W+1:2];
                hold_bout  = e[1];
                hold_ovf   = e[0];
                hold_valid = 1'b1;
            end
        end else if (!busy && hold_valid) begin
            check("hold_diff",  diff, hold_diff);
            check("hold_b_out", {63'd0, b_out}, {63'd0, hold_bout});
            check("hold_ovf",   {63'd0, ovf},   {63'd0, hold_ovf});
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                         input bit on_current_negedge,
                         output logic [W-1:0] rdiff, output logic rbout, output logic rovf);
        int lat, busy_cnt;
        bit got;
        if (!on_current_negedge) @(negedge clk);
        a = oa; b = ob; b_in = obin; start = 1'b1;
        exp_q.push_back(model(oa, ob, obin));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; b_in = 1'($urandom_range(0, 1));
        lat = 0; busy_cnt = 0; got = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            if (lat == 0) check("diff_cleared_on_start", diff, '0);
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
        end
        rdiff = diff; rbout = b_out; rovf = ovf;
        if (!got) begin
            check("done_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end else begin
            check("latency_edges", 64'(lat + 1), 64'd17);
            check("busy_cycles", 64'(busy_cnt), 64'd16);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0]     rd;
        logic             rb, ro;
        logic [EXP_W-1:0] m;
        int               n, t1, t2;

        // Pin the model with hand-computed values.
        m = model(64'hff, 64'h12, 1'b0);
        check("model_ff_12", m[W+1:2], 64'hed);
        m = model(64'h0, 64'h1, 1'b0);
        check("model_0_1_bout", {63'd0, m[1]}, 64'd1);
        m = model(64'h8000_0000_0000_0000, 64'h1, 1'b0);
        check("model_min_1_ovf", {63'd0, m[0]}, 64'd1);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, '0);
        check("rst_done", {63'd0, done}, '0);
        check("rst_diff", diff, '0);
        check("rst_b_out", {63'd0, b_out}, '0);
        check("rst_ovf", {63'd0, ovf}, '0);
        check("rst_state", {62'd0, dbg_state}, '0);
        rst_n = 1'b1;
        hold_valid = 1'b1;

        // Directed vectors.
        do_op(64'hff, 64'h12, 1'b0, 0, rd, rb, ro);
        check("ff_12_diff", rd, 64'hed);
        check("ff_12_bout", {63'd0, rb}, 64'd0);
        check("ff_12_ovf", {63'd0, ro}, 64'd0);
        do_op(64'h0, 64'h1, 1'b0, 0, rd, rb, ro);
        check("0_1_diff", rd, 64'hffff_ffff_ffff_ffff);
        check("0_1_bout", {63'd0, rb}, 64'd1);
        check("0_1_ovf", {63'd0, ro}, 64'd0);
        do_op(64'h5, 64'h5, 1'b1, 0, rd, rb, ro);
        check("5_5_1_diff", rd, 64'hffff_ffff_ffff_ffff);
        check("5_5_1_bout", {63'd0, rb}, 64'd1);
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, rd, rb, ro);
        check("min_1_diff", rd, 64'h7fff_ffff_ffff_ffff);
        check("min_1_ovf", {63'd0, ro}, 64'd1);
        check("min_1_bout", {63'd0, rb}, 64'd0);
        do_op(64'h1, 64'h8000_0000_0000_0000, 1'b0, 0, rd, rb, ro);
        check("1_min_diff", rd, 64'h8000_0000_0000_0001);
        check("1_min_ovf", {63'd0, ro}, 64'd1);
        check("1_min_bout", {63'd0, rb}, 64'd1);
        do_op(64'h1_0000, 64'h1, 1'b0, 0, rd, rb, ro);
        check("borrow_chain_diff", rd, 64'hffff);
        check("borrow_chain_bout", {63'd0, rb}, 64'd0);

        // Start held high throughout, operands changed mid-run, second run from DONE.
        @(negedge clk);
        a = 64'h1234_5678_9abc_def0; b = 64'h0fed_cba9_8765_4321; b_in = 1'b1; start = 1'b1;
        exp_q.push_back(model(a, b, b_in));
        @(posedge clk);
        #1;
        a = 64'h0000_0000_0000_0010; b = 64'h0000_0000_0000_0020; b_in = 1'b0;
        exp_q.push_back(model(a, b, b_in));
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check("held_first_done_seen", {63'd0, done}, 64'd1);
        t1 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check("held_second_done_seen", {63'd0, done}, 64'd1);
        t2 = cyc;
        check("issue_interval", 64'(t2 - t1), 64'd17);
        repeat (25) @(negedge clk);
        check("held_queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset at edge T0+8 of a run.
        @(negedge clk);
        a = 64'hdead_beef_0000_0001; b = 64'h1; b_in = 1'b0; start = 1'b1;
        exp_q.push_back(model(a, b, b_in));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        hold_diff = '0; hold_bout = 1'b0; hold_ovf = 1'b0;
        check("abort_busy", {63'd0, busy}, '0);
        check("abort_done", {63'd0, done}, '0);
        check("abort_diff", diff, '0);
        check("abort_b_out", {63'd0, b_out}, '0);
        check("abort_ovf", {63'd0, ovf}, '0);
        check("abort_state", {62'd0, dbg_state}, '0);
        repeat (20) @(negedge clk);
        do_op(64'h10, 64'h3, 1'b1, 0, rd, rb, ro);
        check("after_abort_diff", rd, 64'hc);

        // Randomised runs, mixing idle gaps and back-to-back issue from DONE.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rbb;
            logic         rbin;
            int           gap;
            ra   = {$urandom, $urandom};
            rbb  = {$urandom, $urandom};
            rbin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rbb = ra;
                1: ra  = '0;
                2: rbb = '1;
                default: ;
            endcase
            gap = $urandom_range(0, 2);
            if (gap > 1) repeat (gap - 1) @(negedge clk);
            do_op(ra, rbb, rbin, (gap == 0), rd, rb, ro);
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_64.md
# serial_subtractor_64

Multi-cycle 64-bit subtractor computing `diff = a - b - b_in`, four bits per clock, with a start/busy/done handshake. It is the inverse-direction companion to the 64-bit ripple adder in the arithmetic datapath: same operand width and same carry/borrow chaining convention. It trades latency for a short critical path and a registered, self-timed result.

## Interface
- `WIDTH`, 64, operand and result width; must be a multiple of `DIGIT`.
- `DIGIT`, 4, bits processed per clock.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on accepted start.
- `b`  in  WIDTH  subtrahend; captured on accepted start.
- `b_in`  in  1  borrow-in; captured on accepted start.
- `busy`  out  1  high while a subtraction is in progress.
- `done`  out  1  one-cycle pulse; `diff`/`b_out`/`ovf` are valid from this cycle on.
- `diff`  out  WIDTH  result, held until the next accepted start.
- `b_out`  out  1  borrow-out: 1 iff unsigned `a < b + b_in`.
- `ovf`  out  1  two's-complement signed overflow of the subtraction.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start=1` latches `a`, `b` and `b_in` into internal registers, clears the digit counter, clears `diff`, and moves to RUN. `start=0` stays in IDLE.
- RUN: each cycle, digit k (bits `[DIGIT*k +: DIGIT]`) computes `a_k - b_k - borrow`. The result is written into `diff[DIGIT*k +: DIGIT]` and the borrow register is updated. k increments from 0 to `WIDTH/DIGIT-1`. After the last digit the state moves to DONE.
- DONE: lasts exactly one cycle with `done=1`. `start=1` is accepted here, same as in IDLE, and goes straight to RUN. Otherwise the state moves to IDLE.
- `start` in RUN is ignored. It is not queued, and operand inputs are don't-care while busy.
- `b_out` is the final borrow.
- `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched operands.
- `b_in` participates only in digit 0; `ovf` ignores any `b_in` effect beyond the formula above.
- All arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset (`rst_n=0` at an edge) forces IDLE and zeroes `busy`, `done`, `diff`, `b_out`, `ovf`, the counter and the operand registers.
- Reset takes priority over `start` and aborts a RUN mid-operation with no `done` pulse.
- Start accepted at edge T0:
  - `busy=1` from after T0 through the edge that writes the last digit.
  - Digits are written at edges T0+1 … T0+16 (for 64/4).
  - `done=1` and outputs are final in the cycle after edge T0+16.
  - Latency is `WIDTH/DIGIT + 1` edges from the accepting edge to `done` being sampled high.
- `busy` and `done` are never high together.
- Back-to-back operation: a start in the DONE cycle gives a 17-cycle issue interval.
- `diff`, `b_out` and `ovf` change only during RUN (`diff` digits), at the final RUN edge (`b_out`, `ovf`), on an accepted start (`diff` cleared), or on reset.

## Structure
- Shared package `arith_pkg`: `WIDTH`/`DIGIT` defaults, `NDIGITS = WIDTH/DIGIT`, the counter width `$clog2(NDIGITS)`, and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module, `sub_digit`: a combinational `DIGIT`-bit borrow-ripple slice with inputs (x, y, bin) and outputs (d, bout). It is instantiated once and muxed by the counter.
- Top level contains the FSM, the counter, the operand/borrow registers and the result register.

## Test plan
- `a=64'hff`, `b=64'h12`, `b_in=0`, one-cycle start → `done` 17 edges later; `diff=64'hed`, `b_out=0`, `ovf=0`; `busy` high for exactly 16 cycles.
- `a=0`, `b=1`, `b_in=0` → `diff=64'hffff_ffff_ffff_ffff`, `b_out=1`, `ovf=0`. Also `a=5`, `b=5`, `b_in=1` → same `diff`, `b_out=1`.
- `a=64'h8000_0000_0000_0000`, `b=1` → `diff=64'h7fff_ffff_ffff_ffff`, `ovf=1`, `b_out=0`.
- Start held high throughout a run with operands changed mid-run → exactly one result for the first operands. A second run starts from the DONE cycle, and its `done` arrives 17 edges after the first `done`.
- `rst_n=0` at edge T0+8 of a run → all outputs 0 next cycle, no `done`. A fresh start afterwards produces a correct result.
- Randomised operands, at least 1000 runs, against the reference `a - b - b_in` and the adder identity `diff + b + b_in == a` (mod 2^64).
